// File: rtl/imm_extend_pipe_pkg.sv
// cpu_defs: mode codes and prefix-state encodings shared by the immediate-generation stage
package cpu_defs;
    localparam logic [1:0] MODE_ZERO   = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b01;
    localparam logic [1:0] MODE_HIGH   = 2'b10;
    localparam logic [1:0] MODE_PREFIX = 2'b11;
    typedef enum logic {
        ST_NO_PFX   = 1'b0,
        ST_PFX_HELD = 1'b1
    } state_t;
endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational zero/sign/high extension of a plain or prefix-concatenated immediate
module imm_extend_core
    import cpu_defs::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [2*IN_W-1:0] value,
    input  logic              use_cat,
    input  logic [1:0]        mode,
    output logic [OUT_W-1:0]  result
);
    logic [IN_W-1:0]  lo;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] high;
    assign lo   = value[IN_W-1:0];
    // size casts of signed operands sign-extend, which also covers OUT_W == 2*IN_W
    assign zext = use_cat ? OUT_W'(value) : OUT_W'(lo);
    assign sext = use_cat ? OUT_W'($signed(value)) : OUT_W'($signed(lo));
    assign high = {lo, {(OUT_W-IN_W){1'b0}}};
    assign result = mode == MODE_HIGH ? high : mode == MODE_SIGN ? sext : zext;
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate generator with prefix concatenation and valid/ready handshakes
module imm_extend_pipe
    import cpu_defs::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_prefixed,
    output logic             prefix_pending
);
    state_t           state;
    state_t           next_state;
    logic [IN_W-1:0]  prefix_reg;
    logic [OUT_W-1:0] result;
    logic             accept;
    logic             is_pfx;
    logic             produce;
    logic             use_cat;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign is_pfx   = in_mode == MODE_PREFIX;
    assign produce  = accept && !is_pfx;
    // HIGH never consumes a held prefix; it simply discards it
    assign use_cat  = state == ST_PFX_HELD && (in_mode == MODE_ZERO || in_mode == MODE_SIGN);

    imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .value  ({prefix_reg, in_imm}),
        .use_cat(use_cat),
        .mode   (in_mode),
        .result (result)
    );

    always_ff @(posedge clk)
        state <= !rst_n ? ST_NO_PFX : next_state;

    always_comb
        next_state = flush ? ST_NO_PFX : !accept ? state : is_pfx ? ST_PFX_HELD : ST_NO_PFX;

    always_comb
        prefix_pending = state == ST_PFX_HELD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_prefixed <= 1'b0;
            prefix_reg   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            prefix_reg <= '0;
        end else begin
            if (accept && is_pfx)
                prefix_reg <= in_imm;
            if (produce) begin
                out_valid    <= 1'b1;
                out_imm      <= result;
                out_prefixed <= use_cat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed table-driven checks of the immediate stage at OUT_W=16 and OUT_W=32
module tb_imm_extend_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_ready = 1'b1;
    logic        rdy16, val16, pfx16, pend16;
    logic        rdy32, val32, pfx32, pend32;
    logic [15:0] imm16;
    logic [31:0] imm32;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy16),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(val16), .out_ready(out_ready),
        .out_imm(imm16), .out_prefixed(pfx16), .prefix_pending(pend16)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(val32), .out_ready(out_ready),
        .out_imm(imm32), .out_prefixed(pfx32), .prefix_pending(pend32)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  imm;
        logic        exp_valid;
        logic [15:0] exp16;
        logic [31:0] exp32;
        logic        exp_pfx;
        logic        exp_pend;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_mode  = m;
        in_imm   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [15:0] e16, input logic p, input logic pend);
        check({name, " valid"}, 32'(val16), 32'(v));
        check({name, " pending"}, 32'(pend16), 32'(pend));
        if (v) begin
            check({name, " imm16"}, 32'(imm16), 32'(e16));
            check({name, " prefixed"}, 32'(pfx16), 32'(p));
        end
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{2'b01, 8'h80, 1'b1, 16'hFF80, 32'hFFFFFF80, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 8'h80, 1'b1, 16'h0080, 32'h00000080, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 8'h12, 1'b1, 16'h1200, 32'h12000000, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 8'h12, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[4]  = '{2'b01, 8'h34, 1'b1, 16'h1234, 32'h00001234, 1'b1, 1'b0};
        vecs[5]  = '{2'b11, 8'h80, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[6]  = '{2'b01, 8'h01, 1'b1, 16'h8001, 32'hFFFF8001, 1'b1, 1'b0};
        vecs[7]  = '{2'b11, 8'h80, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[8]  = '{2'b00, 8'h01, 1'b1, 16'h8001, 32'h00008001, 1'b1, 1'b0};
        vecs[9]  = '{2'b11, 8'h11, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 8'h22, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[11] = '{2'b01, 8'h33, 1'b1, 16'h2233, 32'h00002233, 1'b1, 1'b0};
        vecs[12] = '{2'b11, 8'h44, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[13] = '{2'b10, 8'h56, 1'b1, 16'h5600, 32'h56000000, 1'b0, 1'b0};
        vecs[14] = '{2'b01, 8'h7F, 1'b1, 16'h007F, 32'h0000007F, 1'b0, 1'b0};

        tick();
        tick();
        check("reset valid", 32'(val16), 32'd0);
        check("reset imm", 32'(imm16), 32'd0);
        check("reset prefixed", 32'(pfx16), 32'd0);
        check("reset pending", 32'(pend16), 32'd0);
        check("reset in_ready", 32'(rdy16), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].imm);
            check($sformatf("vec%0d in_ready", i), 32'(rdy16), 32'd1);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp16, vecs[i].exp_pfx, vecs[i].exp_pend);
            check($sformatf("vec%0d valid32", i), 32'(val32), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d imm32", i), imm32, vecs[i].exp32);
                check($sformatf("vec%0d prefixed32", i), 32'(pfx32), 32'(vecs[i].exp_pfx));
            end
        end
        drive(1'b0, 2'b00, 8'h00);
        tick();
        check("drain valid", 32'(val16), 32'd0);

        // backpressure: result held, second request stalled until out_ready rises
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 8'h7F);
        tick();
        check_out("bp first", 1'b1, 16'h007F, 1'b0, 1'b0);
        check("bp in_ready low", 32'(rdy16), 32'd0);
        drive(1'b1, 2'b01, 8'h01);
        tick();
        check_out("bp held", 1'b1, 16'h007F, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp in_ready high", 32'(rdy16), 32'd1);
        tick();
        check_out("bp reload", 1'b1, 16'h0001, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 8'h00);
        tick();
        check("bp drain", 32'(val16), 32'd0);

        // flush drops a held prefix and the same-cycle request
        drive(1'b1, 2'b11, 8'hAB);
        tick();
        check_out("fl prefix", 1'b0, 16'h0, 1'b0, 1'b1);
        drive(1'b1, 2'b01, 8'h05);
        flush = 1'b1;
        tick();
        check_out("fl flushed", 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        tick();
        check_out("fl after", 1'b1, 16'h0005, 1'b0, 1'b0);
        // flush also drops a stalled output
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        check("fl stalled out", 32'(val16), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;

        // reset mid-operation clears everything
        drive(1'b1, 2'b00, 8'h77);
        tick();
        check_out("rs pre", 1'b1, 16'h0077, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 8'hCD);
        tick();
        check_out("rs prefix", 1'b0, 16'h0, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 8'h00);
        rst_n = 1'b0;
        tick();
        check("rs valid", 32'(val16), 32'd0);
        check("rs imm", 32'(imm16), 32'd0);
        check("rs prefixed", 32'(pfx16), 32'd0);
        check("rs pending", 32'(pend16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b10, 8'h01);
        tick();
        check_out("rs high", 1'b1, 16'h0100, 1'b0, 1'b0);
        check("rs high32", imm32, 32'h01000000);
        drive(1'b0, 2'b00, 8'h00);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
